// File: rtl/uart_pkg.sv
// Shared UART constants: divisor/fraction widths and the oversampling ratio.
package uart_pkg;
    localparam int DIV_W      = 16;
    localparam int FRAC_W     = 4;
    localparam int OVERSAMPLE = 16;
    localparam int SUB_W      = $clog2(OVERSAMPLE);

    // A divisor of 0 behaves like 1, so the interval is never shorter than one clock.
    function automatic logic [DIV_W-1:0] eff_div_m1(input logic [DIV_W-1:0] d);
        return (d == '0) ? '0 : d - DIV_W'(1);
    endfunction
endpackage

// File: rtl/uart_frac_divider.sv
// Fractional clock divider: interval counter plus 4-bit phase accumulator that
// stretches F out of every 16 intervals by one clock; emits a registered x16 tick.
module uart_frac_divider
    import uart_pkg::*;
#(
    parameter int COUNTER_WIDTH = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [FRAC_W-1:0] frac,
    output logic              tick
);
    logic [COUNTER_WIDTH-1:0] cnt;
    logic [COUNTER_WIDTH-1:0] len_m1;
    logic [COUNTER_WIDTH-1:0] cur_m1;
    logic [DIV_W-1:0]         deff_m1;
    logic [FRAC_W-1:0]        acc;
    logic [FRAC_W:0]          sum;
    logic                     running;
    logic                     wrap;

    assign deff_m1 = eff_div_m1(divisor);
    assign sum     = {1'b0, acc} + {1'b0, frac};
    // The first interval after activation uses the live divisor, not a stale length.
    assign cur_m1  = running ? len_m1 : COUNTER_WIDTH'(deff_m1);
    assign wrap    = (cnt == cur_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            len_m1  <= '0;
            acc     <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
        end else if (!active) begin
            cnt     <= '0;
            len_m1  <= '0;
            acc     <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
        end else begin
            running <= 1'b1;
            tick    <= wrap;
            if (wrap) begin
                // D and F are sampled only here, so a change never truncates an interval.
                cnt    <= '0;
                acc    <= sum[FRAC_W-1:0];
                len_m1 <= COUNTER_WIDTH'(deff_m1) + COUNTER_WIDTH'(sum[FRAC_W]);
            end else begin
                cnt    <= cnt + COUNTER_WIDTH'(1);
                len_m1 <= cur_m1;
            end
        end
    end
endmodule

// File: rtl/uart_baudgen.sv
// UART baud generator: x16 oversampling tick from the fractional divider and a
// 1x tick on every 16th x16 tick, each gated by its own enable and registered.
module uart_baudgen
    import uart_pkg::*;
#(
    parameter int COUNTER_WIDTH = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DIV_W-1:0]  i_divisor_x16,
    input  logic [FRAC_W-1:0] i_fra_adj_x16,
    input  logic              i_baud_en,
    input  logic              i_baud_x16_en,
    output logic              o_baud,
    output logic              o_baud_x16
);
    logic             active;
    logic             tick;
    logic [SUB_W-1:0] sub;

    assign active = i_baud_en | i_baud_x16_en;

    uart_frac_divider #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_div (
        .clk     (i_clk),
        .rst     (i_rst),
        .active  (active),
        .divisor (i_divisor_x16),
        .frac    (i_fra_adj_x16),
        .tick    (tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sub        <= '0;
            o_baud     <= 1'b0;
            o_baud_x16 <= 1'b0;
        end else if (!active) begin
            sub        <= '0;
            o_baud     <= 1'b0;
            o_baud_x16 <= 1'b0;
        end else begin
            // Phase is kept while either enable is high; each output is only masked.
            o_baud_x16 <= tick & i_baud_x16_en;
            o_baud     <= tick & (sub == SUB_W'(OVERSAMPLE - 1)) & i_baud_en;
            if (tick) begin
                sub <= sub + SUB_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_baudgen.sv
// Self-checking bench for uart_baudgen: tick times predicted from the closed-form
// rule T(n) = n*Deff + floor((n-1)*F/16), edges counted from activation.
module tb_uart_baudgen;
    logic        clk;
    logic        rst;
    logic [15:0] divisor;
    logic [3:0]  frac;
    logic        baud_en;
    logic        baud_x16_en;
    logic        baud;
    logic        baud_x16;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_ticks[$];
    int baud_seen[$];

    uart_baudgen #(
        .COUNTER_WIDTH (20)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_divisor_x16 (divisor),
        .i_fra_adj_x16 (frac),
        .i_baud_en     (baud_en),
        .i_baud_x16_en (baud_x16_en),
        .o_baud        (baud),
        .o_baud_x16    (baud_x16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic build_model(input int d, input int f, input int ncyc);
        int deff;
        int n;
        int t;
        deff = (d == 0) ? 1 : d;
        exp_ticks.delete();
        n = 1;
        t = deff;
        while (t < ncyc) begin
            exp_ticks.push_back(t);
            n++;
            t = n * deff + ((n - 1) * f) / 16;
        end
    endtask

    task automatic go_idle();
        baud_en     = 1'b0;
        baud_x16_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Next rising edge is activation edge 0; compares both outputs every cycle.
    task automatic check_trace(input string name, input int ncyc, input int drop_x_at,
                               input int chg_at, input int chg_d);
        int   qi;
        int   bad_x;
        int   bad_b;
        int   first_x;
        int   first_b;
        logic got_x;
        logic got_b;
        logic want_x;
        logic want_b;
        logic raw;
        logic ex;
        logic eb;
        qi = 0; bad_x = 0; bad_b = 0; first_x = -1; first_b = -1;
        got_x = 1'b0; got_b = 1'b0; want_x = 1'b0; want_b = 1'b0;
        baud_seen.delete();
        for (int e = 0; e < ncyc; e++) begin
            if (e == drop_x_at) baud_x16_en = 1'b0;
            if (e == chg_at) divisor = 16'(chg_d);
            @(posedge clk);
            #1;
            raw = 1'b0;
            if (qi < exp_ticks.size()) raw = (exp_ticks[qi] == e);
            ex = raw & baud_x16_en;
            eb = raw & (((qi + 1) % 16) == 0) & baud_en;
            if (raw) qi++;
            if (baud === 1'b1) baud_seen.push_back(e);
            if (baud_x16 !== ex) begin
                if (first_x < 0) begin first_x = e; got_x = baud_x16; want_x = ex; end
                bad_x++;
            end
            if (baud !== eb) begin
                if (first_b < 0) begin first_b = e; got_b = baud; want_b = eb; end
                bad_b++;
            end
        end
        total_cnt++;
        if (bad_x != 0)
            $display("FAIL %s x16: %0d wrong cycles, first at edge %0d got %b required %b",
                     name, bad_x, first_x, got_x, want_x);
        else pass_cnt++;
        total_cnt++;
        if (bad_b != 0)
            $display("FAIL %s baud: %0d wrong cycles, first at edge %0d got %b required %b",
                     name, bad_b, first_b, got_b, want_b);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; divisor = 16'd1; frac = 4'd0; baud_en = 1'b1; baud_x16_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (baud_x16 !== 1'b0) $display("FAIL reset_x16: got %b required 0", baud_x16);
        else pass_cnt++;
        total_cnt++;
        if (baud !== 1'b0) $display("FAIL reset_baud: got %b required 0", baud);
        else pass_cnt++;
        baud_en = 1'b0; baud_x16_en = 1'b0;
        #3 rst = 1'b0;
        go_idle();
    endtask

    task automatic test_frac_27_8();
        int bad;
        go_idle();
        divisor = 16'd27; frac = 4'd8; baud_en = 1'b1; baud_x16_en = 1'b1;
        build_model(27, 8, 5000);
        check_trace("frac_27_8", 5000, -1, -1, 0);
        bad = (baud_seen.size() < 11) ? 1 : 0;
        for (int i = 1; i < baud_seen.size(); i++)
            if (baud_seen[i] - baud_seen[i-1] != 440) bad++;
        total_cnt++;
        if (bad != 0)
            $display("FAIL period_27_8: %0d pulses, %0d bad gaps, required period 440",
                     baud_seen.size(), bad);
        else pass_cnt++;
    endtask

    task automatic test_integer_divs();
        int bad;
        go_idle();
        divisor = 16'd16; frac = 4'd0; baud_en = 1'b1; baud_x16_en = 1'b1;
        build_model(16, 0, 800);
        check_trace("div_16", 800, -1, -1, 0);
        bad = (baud_seen.size() < 3) ? 1 : 0;
        for (int i = 1; i < baud_seen.size(); i++)
            if (baud_seen[i] - baud_seen[i-1] != 256) bad++;
        total_cnt++;
        if (bad != 0)
            $display("FAIL period_16: %0d pulses, %0d bad gaps, required period 256",
                     baud_seen.size(), bad);
        else pass_cnt++;

        go_idle();
        divisor = 16'd1; frac = 4'd0; baud_en = 1'b1; baud_x16_en = 1'b1;
        build_model(1, 0, 60);
        check_trace("div_1", 60, -1, -1, 0);

        go_idle();
        divisor = 16'd0; frac = 4'd0; baud_en = 1'b1; baud_x16_en = 1'b1;
        build_model(0, 0, 60);
        check_trace("div_0", 60, -1, -1, 0);
    endtask

    task automatic test_random();
        int d;
        int f;
        int deff;
        for (int it = 0; it < 4; it++) begin
            go_idle();
            d = $urandom_range(0, 24);
            f = $urandom_range(0, 15);
            deff = (d == 0) ? 1 : d;
            divisor = 16'(d); frac = 4'(f);
            baud_en = 1'($urandom_range(0, 1));
            baud_x16_en = 1'($urandom_range(0, 1));
            if (!baud_en) baud_x16_en = 1'b1;
            build_model(d, f, 33 * deff + 40);
            check_trace($sformatf("rand_d%0d_f%0d", d, f), 33 * deff + 40, -1, -1, 0);
        end
    endtask

    task automatic test_enables();
        int bad;
        go_idle();
        divisor = 16'd5; frac = 4'd7; baud_en = 1'b1; baud_x16_en = 1'b0;
        build_model(5, 7, 300);
        check_trace("baud_only", 300, -1, -1, 0);
        bad = (baud_seen.size() < 3) ? 1 : 0;
        for (int i = 1; i < baud_seen.size(); i++)
            if (baud_seen[i] - baud_seen[i-1] != 87) bad++;
        total_cnt++;
        if (bad != 0)
            $display("FAIL period_baud_only: %0d pulses, %0d bad gaps, required period 87",
                     baud_seen.size(), bad);
        else pass_cnt++;

        go_idle();
        divisor = 16'd6; frac = 4'd3; baud_en = 1'b1; baud_x16_en = 1'b1;
        build_model(6, 3, 250);
        check_trace("drop_x16_en", 250, 100, -1, 0);

        go_idle();
        divisor = 16'd1; frac = 4'd0; baud_en = 1'b1; baud_x16_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        baud_en = 1'b0; baud_x16_en = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (baud_x16 !== 1'b0) $display("FAIL deactivate_x16: got %b required 0", baud_x16);
        else pass_cnt++;
        total_cnt++;
        if (baud !== 1'b0) $display("FAIL deactivate_baud: got %b required 0", baud);
        else pass_cnt++;

        divisor = 16'd6; frac = 4'd3; baud_en = 1'b1; baud_x16_en = 1'b1;
        build_model(6, 3, 120);
        check_trace("reenable", 120, -1, -1, 0);
    endtask

    task automatic test_async_reset();
        go_idle();
        divisor = 16'd1; frac = 4'd0; baud_en = 1'b1; baud_x16_en = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (baud_x16 !== 1'b0) $display("FAIL async_reset_x16: got %b required 0", baud_x16);
        else pass_cnt++;
        total_cnt++;
        if (baud !== 1'b0) $display("FAIL async_reset_baud: got %b required 0", baud);
        else pass_cnt++;
        divisor = 16'd12; frac = 4'd3;
        #3;
        rst = 1'b0;
        build_model(12, 3, 500);
        check_trace("after_reset", 500, -1, -1, 0);
    endtask

    task automatic test_div_change();
        go_idle();
        divisor = 16'd10; frac = 4'd0; baud_en = 1'b1; baud_x16_en = 1'b1;
        exp_ticks.delete();
        exp_ticks.push_back(10);
        exp_ticks.push_back(20);
        exp_ticks.push_back(30);
        exp_ticks.push_back(40);
        exp_ticks.push_back(60);
        exp_ticks.push_back(80);
        exp_ticks.push_back(100);
        check_trace("div_change", 110, -1, 35, 20);
    endtask

    initial begin
        rst = 1'b1; divisor = '0; frac = '0; baud_en = 1'b0; baud_x16_en = 1'b0;
        test_reset();
        test_frac_27_8();
        test_integer_divs();
        test_random();
        test_enables();
        test_async_reset();
        test_div_change();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
